rv32_mod_instruction_prefetch: RTL and testbench
================================================

RV32_MOD_INSTRUCTION_PREFETCH -- requirements
Module: rv32_mod_instruction_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have ports: clk input 1, clock; reset input 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports: if_redirect input 1, flush and restart fetch; if_redirect_addr input 32, new fetch PC.
REQ-005 SHALL have ports: if_ready input 1, hart consumes head; if_valid output 1, head valid; if_instruction output 32, head word; if_pc output 32, head address; if_fault output 1, head is a bus fault.
REQ-006 SHALL have ports: instr_req output 1; instr_addr output 32; instr_ack input 1; instr_err input 1; instr_data_i input 32.

Function
REQ-007 SHALL hold one bus request outstanding at most; instr_req and instr_addr stay stable from assertion until the cycle instr_ack or instr_err is sampled high.
REQ-008 SHALL assert instr_req only when FIFO occupancy plus in-flight count < DEPTH and fetch is not halted.
REQ-009 SHALL push {instr_data_i, instr_addr, fault=0} on instr_ack, advance the fetch PC by 4, and allow a new request in the following cycle.
REQ-010 SHALL show a pushed entry at the head one cycle after ack at the earliest (ack cycle N -> if_valid cycle N+1).
REQ-011 SHALL assert if_valid when the FIFO is non-empty; it pops the head when if_valid && if_ready.
REQ-012 SHALL drive if_instruction = 32'h0000_0013 (NOP), if_pc = 0, if_fault = 0 when empty.
REQ-013 SHALL allow a push and a pop in the same cycle, occupancy unchanged; pointers wrap modulo DEPTH.
REQ-014 SHALL, on if_redirect, empty the FIFO next cycle, set fetch PC to if_redirect_addr, and clear halt; a pop requested in the same cycle is ignored.
REQ-015 SHALL, on a redirect with a request in flight, keep the old request asserted until ack/err, discard its response (no push), then request if_redirect_addr.
REQ-016 SHALL, on a redirect coinciding with ack/err of the in-flight request, discard that response and request if_redirect_addr the next cycle.
REQ-017 SHALL treat simultaneous instr_ack and instr_err as instr_err.

Reset
REQ-018 SHALL, while reset is high, clear FIFO, in-flight and halt state, drive instr_req = 0 and if_valid = 0, and set fetch PC = RESET_ADDR.
REQ-019 SHALL assert the first instr_req in the first clk edge after reset deasserts, with instr_addr = RESET_ADDR.
REQ-020 SHALL discard any request in flight at reset; no response after reset is pushed until a new request is issued.

Configuration
REQ-021 SHALL, with RV32_IF_FAULT_EN defined, push {NOP, instr_addr, fault=1} on instr_err and halt fetching until if_redirect.
REQ-022 SHALL, without RV32_IF_FAULT_EN, never push on instr_err, retry the same address next cycle, and tie if_fault to 0.

Verification
REQ-023 SHALL cover: reset release, ack every cycle, if_ready=1 -> addresses 0,4,8,... each ack N yields if_valid at N+1, matching if_pc/data.
REQ-024 SHALL cover: DEPTH=4, if_ready=0 -> exactly 4 acks accepted, instr_req low after, resumes one cycle after the first pop.
REQ-025 SHALL cover: redirect to 0x100 while request to 0x8 in flight, ack 3 cycles later -> 0x8 data not output, next instr_addr=0x100.
REQ-026 SHALL cover: redirect with if_valid && if_ready same cycle -> FIFO empty next cycle, no head popped to hart.
REQ-027 SHALL cover: instr_err at 0x10 -> with RV32_IF_FAULT_EN, if_fault=1, if_pc=0x10, no requests until redirect; without it, instr_addr=0x10 reissued, if_fault stays 0.
REQ-028 SHALL cover: reset asserted mid-request with FIFO holding 2 entries -> if_valid=0, instr_req=0 at once; after release, instr_addr=RESET_ADDR.

Source files
------------

// File: rtl/rv32_mod_instruction_prefetch.sv
// RV32 instruction prefetch unit.
// Keeps at most one instruction-bus request outstanding and queues fetched
// words in a DEPTH-entry FIFO that the hart drains through if_valid/if_ready.
// A redirect flushes the queue, restarts fetch at a new PC, and drops the
// response of any request that is still in flight.
// Optional feature macro: RV32_IF_FAULT_EN. When defined, bus errors are
// queued as fault entries and fetch halts until the next redirect. When not
// defined, a bus error causes the same address to be retried.
module rv32_mod_instruction_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_redirect,
  input  logic [31:0] if_redirect_addr,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_fault,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_ack,
  input  logic        instr_err,
  input  logic [31:0] instr_data_i
);

  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Request stage (p0) and queue state
  logic              req_p0;
  logic [31:0]       addr_p0;
  logic              discard_p0;
  logic              halt_p0;
  logic [31:0]       fetch_pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       mem_data [DEPTH];
  logic [31:0]       mem_pc   [DEPTH];

  logic              resp_ack;
  logic              resp_err;
  logic              resp;
  logic              live;
  logic              push;
  logic              push_fault;
  logic              pop;
  logic              issue;
  logic              halt_next;
  logic              discard_next;
  logic [CNT_W-1:0]  count_next;
  logic [31:0]       pc_next;

  // Response decode, queue occupancy and next fetch decision
  always_comb begin
    resp_err     = req_p0 && instr_err;
    resp_ack     = req_p0 && instr_ack && !instr_err;
    resp         = resp_ack || resp_err;
    live         = resp && !discard_p0 && !if_redirect;
`ifdef RV32_IF_FAULT_EN
    push         = live;
    push_fault   = live && resp_err;
`else
    push         = live && resp_ack;
    push_fault   = 1'b0;
`endif
    pop          = (count != '0) && if_ready && !if_redirect;
    count_next   = if_redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    halt_next    = if_redirect ? 1'b0 : (halt_p0 || push_fault);
    pc_next      = if_redirect ? if_redirect_addr :
                   (live && resp_ack) ? fetch_pc + 32'd4 : fetch_pc;
    issue        = (!req_p0 || resp) && !halt_next && (count_next < DEPTH_C);
    discard_next = discard_p0;
    if (resp)
      discard_next = 1'b0;
    else if (req_p0 && if_redirect)
      discard_next = 1'b1;
  end

  // Control state: request handshake, fetch PC, halt and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_p0     <= 1'b0;
      discard_p0 <= 1'b0;
      halt_p0    <= 1'b0;
      fetch_pc   <= RESET_ADDR;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (issue)
        req_p0 <= 1'b1;
      else if (resp)
        req_p0 <= 1'b0;
      discard_p0 <= discard_next;
      halt_p0    <= halt_next;
      fetch_pc   <= pc_next;
      count      <= count_next;
      if (if_redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Datapath: request address and FIFO storage (no reset needed)
  always_ff @(posedge clk) begin
    if (issue)
      addr_p0 <= pc_next;
    if (push) begin
      mem_data[wr_ptr] <= resp_err ? NOP : instr_data_i;
      mem_pc[wr_ptr]   <= addr_p0;
    end
  end

`ifdef RV32_IF_FAULT_EN
  logic mem_fault [DEPTH];

  // Fault flag storage alongside each queued word
  always_ff @(posedge clk) begin
    if (push)
      mem_fault[wr_ptr] <= push_fault;
  end

  assign if_fault = (count != '0) ? mem_fault[rd_ptr] : 1'b0;
`else
  assign if_fault = 1'b0;
`endif

  assign instr_req      = req_p0;
  assign instr_addr     = addr_p0;
  assign if_valid       = (count != '0);
  assign if_instruction = if_valid ? mem_data[rd_ptr] : NOP;
  assign if_pc          = if_valid ? mem_pc[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_rv32_mod_instruction_prefetch.sv
// Directed bench for rv32_mod_instruction_prefetch (DEPTH=4, RESET_ADDR=0).
// A table of per-cycle vectors covers streaming and FIFO fill/drain; short
// hand-written sequences cover redirects, bus errors and mid-request reset.
module tb_rv32_mod_instruction_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_redirect;
  logic [31:0] if_redirect_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_fault;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_i;

  int errors = 0;
  int checks = 0;

  rv32_mod_instruction_prefetch #(.DEPTH(4), .RESET_ADDR(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_redirect      (if_redirect),
    .if_redirect_addr (if_redirect_addr),
    .if_ready         (if_ready),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_fault         (if_fault),
    .instr_req        (instr_req),
    .instr_addr       (instr_addr),
    .instr_ack        (instr_ack),
    .instr_err        (instr_err),
    .instr_data_i     (instr_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        ready;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic row(input logic ack, input logic ready, input logic [31:0] data,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic evld, input logic [31:0] epc);
    vec_t v;
    v.ack = ack; v.ready = ready; v.data = data;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evld;
    v.exp_pc = evld ? epc : 32'h0;
    v.exp_instr = evld ? dat(epc) : NOP;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_redirect = 1'b0; if_redirect_addr = 32'h0; if_ready = 1'b0;
    instr_ack = 1'b0; instr_err = 1'b0; instr_data_i = 32'h0;
  endtask

  task automatic chk_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                         input logic evld, input logic [31:0] epc);
    chk({tag, ".req"}, {31'h0, instr_req}, {31'h0, ereq});
    if (ereq) chk({tag, ".addr"}, instr_addr, eaddr);
    chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, evld});
    chk({tag, ".pc"}, if_pc, evld ? epc : 32'h0);
    chk({tag, ".instr"}, if_instruction, evld ? dat(epc) : NOP);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Streaming: ack every cycle, ready high (rows 0-4)
    row(0, 0, 32'h0,        1, 32'h00, 0, 32'h00);
    row(1, 1, dat(32'h00),  1, 32'h04, 1, 32'h00);
    row(1, 1, dat(32'h04),  1, 32'h08, 1, 32'h04);
    row(1, 1, dat(32'h08),  1, 32'h0C, 1, 32'h08);
    row(0, 1, 32'h0,        1, 32'h0C, 0, 32'h00);
    // Fill with ready low: four acks accepted then request drops (rows 5-9)
    row(1, 0, dat(32'h0C),  1, 32'h10, 1, 32'h0C);
    row(1, 0, dat(32'h10),  1, 32'h14, 1, 32'h0C);
    row(1, 0, dat(32'h14),  1, 32'h18, 1, 32'h0C);
    row(1, 0, dat(32'h18),  0, 32'h00, 1, 32'h0C);
    row(1, 0, dat(32'hFFF), 0, 32'h00, 1, 32'h0C);
    // First pop reopens fetch; then push+pop and drain across pointer wrap
    row(0, 1, 32'h0,        1, 32'h1C, 1, 32'h10);
    row(0, 0, 32'h0,        1, 32'h1C, 1, 32'h10);
    row(1, 1, dat(32'h1C),  1, 32'h20, 1, 32'h14);
    row(0, 1, 32'h0,        1, 32'h20, 1, 32'h18);
    row(0, 1, 32'h0,        1, 32'h20, 1, 32'h1C);
    row(0, 1, 32'h0,        1, 32'h20, 0, 32'h00);

    // Reset state
    tick();
    tick();
    chk("rst.req", {31'h0, instr_req}, 32'h0);
    chk("rst.valid", {31'h0, if_valid}, 32'h0);
    chk("rst.instr", if_instruction, NOP);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.fault", {31'h0, if_fault}, 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      instr_ack    = tbl[i].ack;
      if_ready     = tbl[i].ready;
      instr_data_i = tbl[i].data;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
              tbl[i].exp_valid, tbl[i].exp_pc);
      chk($sformatf("vec%0d.fault", i), {31'h0, if_fault}, 32'h0);
    end

    // Redirect to 0x100 while request to 0x8 in flight, ack three cycles later
    do_reset();
    tick();
    instr_ack = 1'b1; instr_data_i = dat(32'h0);
    tick();
    instr_data_i = dat(32'h4);
    tick();
    instr_ack = 1'b0;
    chk_out("rd0", 1, 32'h08, 1, 32'h00);
    if_redirect = 1'b1; if_redirect_addr = 32'h100;
    tick();
    if_redirect = 1'b0;
    chk_out("rd1", 1, 32'h08, 0, 32'h0);
    tick();
    tick();
    instr_ack = 1'b1; instr_data_i = dat(32'h8);
    tick();
    chk_out("rd2", 1, 32'h100, 0, 32'h0);
    instr_data_i = dat(32'h100); if_ready = 1'b1;
    tick();
    instr_ack = 1'b0;
    chk_out("rd3", 1, 32'h104, 1, 32'h100);

    // Redirect with valid && ready in the same cycle: head dropped, not popped
    if_redirect = 1'b1; if_redirect_addr = 32'h200;
    tick();
    if_redirect = 1'b0;
    chk_out("rp0", 1, 32'h104, 0, 32'h0);
    instr_ack = 1'b1; instr_data_i = dat(32'h104);
    tick();
    chk_out("rp1", 1, 32'h200, 0, 32'h0);
    instr_data_i = dat(32'h200); if_ready = 1'b0;
    tick();
    instr_ack = 1'b0;
    chk_out("rp2", 1, 32'h204, 1, 32'h200);

    // Redirect coinciding with ack: response dropped, new address next cycle
    instr_ack = 1'b1; instr_data_i = dat(32'h204);
    if_redirect = 1'b1; if_redirect_addr = 32'h10;
    tick();
    if_redirect = 1'b0; instr_ack = 1'b0;
    chk_out("ra0", 1, 32'h10, 0, 32'h0);

    // Bus error at 0x10
    instr_err = 1'b1;
    tick();
    instr_err = 1'b0;
`ifdef RV32_IF_FAULT_EN
    chk("er0.req", {31'h0, instr_req}, 32'h0);
    chk("er0.valid", {31'h0, if_valid}, 32'h1);
    chk("er0.fault", {31'h0, if_fault}, 32'h1);
    chk("er0.pc", if_pc, 32'h10);
    chk("er0.instr", if_instruction, NOP);
    tick();
    tick();
    chk("er1.req", {31'h0, instr_req}, 32'h0);
    if_redirect = 1'b1; if_redirect_addr = 32'h40;
    tick();
    if_redirect = 1'b0;
    chk("er2.req", {31'h0, instr_req}, 32'h1);
    chk("er2.addr", instr_addr, 32'h40);
    chk("er2.valid", {31'h0, if_valid}, 32'h0);
    chk("er2.fault", {31'h0, if_fault}, 32'h0);
`else
    chk_out("er0", 1, 32'h10, 0, 32'h0);
    chk("er0.fault", {31'h0, if_fault}, 32'h0);
    instr_err = 1'b1; instr_ack = 1'b1; instr_data_i = dat(32'h10);
    tick();
    instr_err = 1'b0;
    chk_out("er1", 1, 32'h10, 0, 32'h0);
    tick();
    instr_ack = 1'b0;
    chk_out("er2", 1, 32'h14, 1, 32'h10);
    chk("er2.fault", {31'h0, if_fault}, 32'h0);
`endif

    // Reset mid-request with two entries queued
    do_reset();
    tick();
    instr_ack = 1'b1; instr_data_i = dat(32'h0);
    tick();
    instr_data_i = dat(32'h4);
    tick();
    instr_ack = 1'b0;
    chk_out("mr0", 1, 32'h08, 1, 32'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("mr1.req", {31'h0, instr_req}, 32'h0);
    chk("mr1.valid", {31'h0, if_valid}, 32'h0);
    tick();
    reset = 1'b0;
    instr_ack = 1'b1; instr_data_i = dat(32'h8);
    tick();
    chk_out("mr2", 1, 32'h00, 0, 32'h0);
    instr_data_i = dat(32'h0);
    tick();
    instr_ack = 1'b0;
    chk_out("mr3", 1, 32'h04, 1, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
